// File: rtl/ex_div_sched.sv
// ex_div_sched: sequencing controller between the EX stage and the
// signed/unsigned divider cores. It accepts one request at a time and issues
// it to the selected core. The 2*DATA_W result is held until EX takes it.
// A result still in flight when a flush arrives is drained and thrown away,
// because the cores cannot be aborted.
//
// Optional feature macro: DIV_ZERO_BYPASS_EN
//   When defined, a zero divisor seen in IDLE completes immediately with
//   {quotient = 0, remainder = dividend}, and neither core is issued.
module ex_div_sched #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic                  req_signed,
  input  logic [DATA_W-1:0]     req_dividend,
  input  logic [DATA_W-1:0]     req_divisor,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_result,
  input  logic                  out_accept,
  output logic                  busy,
  output logic                  draining,
  output logic                  sdiv_src_valid,
  input  logic                  sdiv_src_ready,
  input  logic                  sdiv_res_valid,
  input  logic [2*DATA_W-1:0]   sdiv_res_data,
  output logic                  udiv_src_valid,
  input  logic                  udiv_src_ready,
  input  logic                  udiv_res_valid,
  input  logic [2*DATA_W-1:0]   udiv_res_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic                sel_signed;
  logic [2*DATA_W-1:0] result_q;

  // Handshake and result lines of whichever core owns the current request;
  // the other core's result line is never looked at.
  logic                src_ready_sel;
  logic                res_valid_sel;
  logic [2*DATA_W-1:0] res_data_sel;

  logic                capture;
  logic                bypass;

  assign src_ready_sel = sel_signed ? sdiv_src_ready : udiv_src_ready;
  assign res_valid_sel = sel_signed ? sdiv_res_valid : udiv_res_valid;
  assign res_data_sel  = sel_signed ? sdiv_res_data  : udiv_res_data;

`ifndef DIV_ZERO_BYPASS_EN
  // Operands go straight to the cores; only the bypass path reads them here.
  logic unused_operands;
  assign unused_operands = ^{req_dividend, req_divisor};
`endif

  // Next-state selection; flush takes priority over accept, and a flush that
  // meets an outstanding core operation turns it into a drain.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    bypass    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !flush) begin
`ifdef DIV_ZERO_BYPASS_EN
          if (req_divisor == '0) begin
            state_nxt = DONE;
            bypass    = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
`else
          state_nxt = ISSUE;
`endif
        end
      end
      ISSUE: begin
        if (src_ready_sel && flush)  state_nxt = DRAIN;
        else if (src_ready_sel)      state_nxt = WAIT;
        else if (flush)              state_nxt = IDLE;
      end
      WAIT: begin
        if (res_valid_sel && flush) begin
          state_nxt = IDLE;
        end else if (res_valid_sel) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DONE: begin
        if (flush || out_accept) state_nxt = IDLE;
      end
      DRAIN: begin
        if (res_valid_sel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, core selection and held result; reset drops everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel_signed <= 1'b0;
      result_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == ISSUE) sel_signed <= req_signed;
      if (capture)     result_q <= res_data_sel;
      else if (bypass) result_q <= {{DATA_W{1'b0}}, req_dividend};
    end
  end

  assign busy           = (state != IDLE);
  assign draining       = (state == DRAIN);
  assign out_valid      = (state == DONE);
  assign out_result     = out_valid ? result_q : '0;
  assign sdiv_src_valid = (state == ISSUE) &&  sel_signed;
  assign udiv_src_valid = (state == ISSUE) && !sel_signed;

endmodule
